// File: rtl/spi_slave_if_pkg.sv
// ============================================================
// spi_slave_if_pkg : shared types/constants for the SPI slave | rev 1.0
// ============================================================
`default_nettype none

package spi_slave_if_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int WORD_W_DEF = DATA_W_DEF + 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  // Sub-phase inside WRITE / READ_ADD / READ_DATA
  typedef enum logic [1:0] {
    PH_RX   = 2'd0,
    PH_WAIT = 2'd1,
    PH_TX   = 2'd2,
    PH_HOLD = 2'd3
  } phase_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

`default_nettype wire

// File: rtl/spi_shift_reg.sv
// ============================================================
// spi_shift_reg : SIPO / PISO shift register with bit counter | rev 1.0
// ============================================================
`default_nettype none

module spi_shift_reg #(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic             ser_i,
  input  logic [W-1:0]     par_i,
  output logic [W-1:0]     par_o,
  output logic             ser_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [W-1:0]     data_q;
  logic [CNT_W-1:0] cnt_q;

  // Clear only resets the counter; data is kept so a finished word stays readable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      cnt_q  <= '0;
    end else if (load_i) begin
      data_q <= par_i;
      cnt_q  <= '0;
    end else if (shift_en_i) begin
      data_q <= {data_q[W-2:0], ser_i};
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign par_o = data_q;
  assign ser_o = data_q[W-1];
  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave_if.sv
// ============================================================
// spi_slave_if : SPI mode-0 slave serial front end (MOSI->word, data->MISO) | rev 1.0
// ============================================================
`default_nettype none

module spi_slave_if
  import spi_slave_if_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WORD_W = DATA_W + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int RX_CW = $clog2(WORD_W + 1);
  localparam int TX_CW = $clog2(DATA_W + 1);
  localparam logic [RX_CW-1:0] C_RX_FULL = RX_CW'(WORD_W);
  localparam logic [TX_CW-1:0] C_TX_LAST = TX_CW'(DATA_W - 1);

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [WORD_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rd_addr_seen_q, rd_addr_seen_d;

  logic                rx_shift, rx_clr, tx_load, tx_shift, tx_clr;
  logic [WORD_W-1:0]   rx_word;
  logic                rx_ser;
  logic [RX_CW-1:0]    rx_cnt;
  logic [DATA_W-1:0]   tx_par;
  logic                tx_msb;
  logic [TX_CW-1:0]    tx_cnt;

  spi_shift_reg #(.W(WORD_W), .CNT_W(RX_CW)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (rx_clr),
    .load_i    (1'b0),
    .shift_en_i(rx_shift),
    .ser_i     (MOSI),
    .par_i     ('0),
    .par_o     (rx_word),
    .ser_o     (rx_ser),
    .cnt_o     (rx_cnt)
  );

  spi_shift_reg #(.W(DATA_W), .CNT_W(TX_CW)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (tx_clr),
    .load_i    (tx_load),
    .shift_en_i(tx_shift),
    .ser_i     (1'b0),
    .par_i     (tx_data),
    .par_o     (tx_par),
    .ser_o     (tx_msb),
    .cnt_o     (tx_cnt)
  );

  logic unused_sigs;
  assign unused_sigs = ^{rx_ser, tx_par};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      phase_q        <= PH_RX;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    rx_shift       = 1'b0;
    rx_clr         = 1'b0;
    tx_load        = 1'b0;
    tx_shift       = 1'b0;
    tx_clr         = 1'b0;

    // Deselect wins over everything: drop the partial word and any MISO shift.
    if (state_q != IDLE && SS_n) begin
      state_d = IDLE;
      phase_d = PH_RX;
      rx_clr  = 1'b1;
      tx_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          phase_d = PH_RX;
          if (!SS_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          rx_shift = 1'b1;
          if (!MOSI)               state_d = WRITE;
          else if (!rd_addr_seen_q) state_d = READ_ADD;
          else                      state_d = READ_DATA;
        end
        WRITE, READ_ADD, READ_DATA: begin
          case (phase_q)
            PH_RX: begin
              if (rx_cnt == C_RX_FULL) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
                rx_clr     = 1'b1;
                if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
                phase_d = (state_q == READ_DATA) ? PH_WAIT : PH_HOLD;
              end else begin
                rx_shift = 1'b1;
              end
            end
            PH_WAIT: begin
              if (tx_valid) begin
                tx_load = 1'b1;
                phase_d = PH_TX;
              end
            end
            PH_TX: begin
              tx_shift = 1'b1;
              if (tx_cnt == C_TX_LAST) begin
                phase_d        = PH_HOLD;
                rd_addr_seen_d = 1'b0;
              end
            end
            default: ;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign MISO     = (state_q == READ_DATA && phase_q == PH_TX) ? tx_msb : 1'b0;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

`default_nettype wire
